data_mem_arbiter: RTL and testbench

Front-end controller for the single-ported data memory (128 x 32, synchronous read and write, one command per clock). It shares the memory between two requesters: port 0, the CPU load/store stage, and port 1, the loader/debug DMA. It uses a valid/grant handshake with round-robin arbitration and registers every memory command. After each reset it runs a hardware zero-fill sweep of all locations before it grants any request.

---
 rtl/data_mem_arbiter_if.sv | 47 ++++
 rtl/data_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Requester handshake ports and registered command bus of the data memory arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              init_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_memWrite;
    logic              mem_memRead;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_read_data,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output init_done, mem_addr, mem_write_data, mem_memWrite, mem_memRead
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_read_data,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  init_done, mem_addr, mem_write_data, mem_memWrite, mem_memRead
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin front end for the single-ported data memory: zero-fills the
// memory after reset, then registers one arbitrated command per clock.
module data_mem_arbiter #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_arbiter_if.slave   bus
);
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              rr_last_reg;

    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_write_reg;
    logic              mem_read_reg;
    logic              cmd_owner_reg;
    logic              rsp_valid_reg;
    logic              rsp_owner_reg;

    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [1:0]        gnt_vec;
    logic [1:0]        rvalid_vec;
    logic [ADDR_W-1:0] addr_arr  [2];
    logic [DATA_W-1:0] wdata_arr [2];
    logic [DATA_W-1:0] rdata_arr [2];

    logic              transfer;
    logic              winner;

    assign req_vec      = {bus.m1_req, bus.m0_req};
    assign we_vec       = {bus.m1_we, bus.m0_we};
    assign addr_arr[0]  = bus.m0_addr;
    assign addr_arr[1]  = bus.m1_addr;
    assign wdata_arr[0] = bus.m0_wdata;
    assign wdata_arr[1] = bus.m1_wdata;

    // Grants are only issued in RUN; a contested cycle goes to the port that did not win last.
    always_comb begin
        state_next = state_reg;
        gnt_vec    = 2'b00;
        case (state_reg)
            CLEAR: begin
                if (&clr_cnt_reg) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (req_vec[0] && (!req_vec[1] || rr_last_reg)) begin
                    gnt_vec[0] = 1'b1;
                end else if (req_vec[1]) begin
                    gnt_vec[1] = 1'b1;
                end
            end
            default: state_next = RESET_STATE;
        endcase
    end

    assign transfer = |gnt_vec;
    assign winner   = gnt_vec[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_reg   <= '0;
            rr_last_reg   <= 1'b1;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_write_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
            cmd_owner_reg <= 1'b0;
        end else if (state_reg == CLEAR) begin
            clr_cnt_reg   <= clr_cnt_reg + 1'b1;
            mem_addr_reg  <= clr_cnt_reg;
            mem_wdata_reg <= '0;
            mem_write_reg <= 1'b1;
            mem_read_reg  <= 1'b0;
        end else if (transfer) begin
            rr_last_reg   <= winner;
            cmd_owner_reg <= winner;
            mem_addr_reg  <= addr_arr[winner];
            mem_wdata_reg <= wdata_arr[winner];
            mem_write_reg <= we_vec[winner];
            mem_read_reg  <= !we_vec[winner];
        end else begin
            mem_write_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
        end
    end

    // The memory answers one cycle after the read strobe, so the owner tag trails it by one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_owner_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= mem_read_reg;
            rsp_owner_reg <= cmd_owner_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            assign rvalid_vec[gi] = rsp_valid_reg && (rsp_owner_reg == 1'(gi));
            assign rdata_arr[gi]  = rvalid_vec[gi] ? bus.mem_read_data : '0;
        end
    endgenerate

    assign bus.m0_gnt         = gnt_vec[0];
    assign bus.m1_gnt         = gnt_vec[1];
    assign bus.m0_rvalid      = rvalid_vec[0];
    assign bus.m1_rvalid      = rvalid_vec[1];
    assign bus.m0_rdata       = rdata_arr[0];
    assign bus.m1_rdata       = rdata_arr[1];
    assign bus.init_done      = (state_reg == RUN);
    assign bus.mem_addr       = mem_addr_reg;
    assign bus.mem_write_data = mem_wdata_reg;
    assign bus.mem_memWrite   = mem_write_reg;
    assign bus.mem_memRead    = mem_read_reg;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: stimulus pushes expected read responses into a
// scoreboard queue, a forked monitor pops and compares them as rvalid appears.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    data_mem_arbiter #(
        .ADDR_W(7),
        .DATA_W(32),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Synchronous 128x32 memory; starts with non-zero contents so the sweep is observable.
    logic [31:0] mem_model [128];
    logic [31:0] rd_reg = 32'h0;
    bit          mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 128; i++) mem_model[i] <= 32'hA5A50000 | 32'(i);
            mem_init_done <= 1'b1;
        end else begin
            if (bus.mem_memWrite) mem_model[bus.mem_addr] <= bus.mem_write_data;
            if (bus.mem_memRead)  rd_reg <= mem_model[bus.mem_addr];
        end
    end
    assign bus.mem_read_data = rd_reg;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t        e;
        logic        act_port;
        logic [31:0] act_data;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!bus.m0_rvalid) chk("m0_rdata_idle", bus.m0_rdata, 32'h0);
                if (!bus.m1_rvalid) chk("m1_rdata_idle", bus.m1_rdata, 32'h0);
                if (bus.m0_rvalid || bus.m1_rvalid) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL rsp_unexpected: got m0_rvalid=%0b m1_rvalid=%0b, expected none (t=%0t)",
                                 bus.m0_rvalid, bus.m1_rvalid, $time);
                    end else begin
                        e        = sb.pop_front();
                        act_port = bus.m1_rvalid;
                        act_data = act_port ? bus.m1_rdata : bus.m0_rdata;
                        chk("rsp_one_port", 32'(bus.m0_rvalid & bus.m1_rvalid), 32'h0);
                        chk("rsp_port", 32'(act_port), 32'(e.port));
                        chk("rsp_data", act_data, e.data);
                        $display("rsp: port=%0d data=%h (want port=%0d data=%h)",
                                 act_port, act_data, e.port, e.data);
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [6:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
    endtask

    // Issues one command alone on port p: grant expected in the request cycle,
    // strobe in the following one. Returns one cycle after the grant.
    task automatic single(input int p, input logic we, input logic [6:0] addr, input logic [31:0] d);
        exp_t e;
        set_port(p, 1'b1, we, addr, d);
        #1;
        chk("single_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), (p == 0) ? 32'h1 : 32'h2);
        if (!we) begin
            e.port = 1'(p);
            e.data = d;
            sb.push_back(e);
        end
        $display("cmd: port=%0d we=%0b addr=%0d data=%h", p, we, addr, d);
        cyc();
        set_port(p, 1'b0, 1'b0, 7'd0, 32'h0);
        chk("single_write", 32'(bus.mem_memWrite), 32'(we));
        chk("single_read", 32'(bus.mem_memRead), 32'(!we));
        chk("single_addr", 32'(bus.mem_addr), 32'(addr));
        if (we) chk("single_wdata", bus.mem_write_data, d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rst_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'h0);
        chk("rst_rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'h0);
        chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
        chk("rst_m1_rdata", bus.m1_rdata, 32'h0);
        chk("rst_strobes", 32'({bus.mem_memWrite, bus.mem_memRead}), 32'h0);
        chk("rst_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_wdata", bus.mem_write_data, 32'h0);
        chk("rst_init_done", 32'(bus.init_done), 32'h0);
        cyc();
        rst_n = 1'b1;
        $display("reset released");
    endtask

    // Cycle 0 is the current cycle; walks cycles 1..128 of the zero-fill sweep.
    task automatic sweep(input bit with_req);
        chk("sweep_c0_write", 32'(bus.mem_memWrite), 32'h0);
        chk("sweep_c0_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'h0);
        for (int k = 1; k <= 128; k++) begin
            cyc();
            chk("sweep_write", 32'(bus.mem_memWrite), 32'h1);
            chk("sweep_read", 32'(bus.mem_memRead), 32'h0);
            chk("sweep_addr", 32'(bus.mem_addr), 32'(k - 1));
            chk("sweep_wdata", bus.mem_write_data, 32'h0);
            chk("sweep_init_done", 32'(bus.init_done), (k == 128) ? 32'h1 : 32'h0);
            chk("sweep_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), (with_req && k == 128) ? 32'h1 : 32'h0);
        end
        $display("sweep: 128 cycles walked (with_req=%0b)", with_req);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        fork
            monitor();
        join_none

        // Reset and a plain sweep, then idle cycle with no command.
        cyc();
        do_reset();
        sweep(1'b0);
        cyc();
        chk("post_sweep_idle", 32'({bus.mem_memWrite, bus.mem_memRead}), 32'h0);
        chk("post_sweep_addr_hold", 32'(bus.mem_addr), 32'd127);

        // Write then read back address 5 on port 0.
        single(0, 1'b1, 7'd5, 32'hDEADBEEF);
        single(0, 1'b0, 7'd5, 32'hDEADBEEF);
        chk("rd5_rvalid_n1", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'h0);
        cyc();
        chk("rd5_rvalid_n2", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'h1);
        chk("rd5_rdata_n2", bus.m0_rdata, 32'hDEADBEEF);

        // Contested reads alternate, starting with port 0 because port 1 won last.
        single(0, 1'b1, 7'd1, 32'h000000A1);
        single(1, 1'b1, 7'd2, 32'h000000B2);
        set_port(0, 1'b1, 1'b0, 7'd1, 32'h0);
        set_port(1, 1'b1, 1'b0, 7'd2, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), (i % 2 == 0) ? 32'h1 : 32'h2);
            e.port = 1'(i % 2);
            e.data = (i % 2 == 0) ? 32'h000000A1 : 32'h000000B2;
            sb.push_back(e);
            $display("cmd: contested read, expected winner port=%0d", i % 2);
            cyc();
        end
        set_port(0, 1'b0, 1'b0, 7'd0, 32'h0);
        set_port(1, 1'b0, 1'b0, 7'd0, 32'h0);
        repeat (3) cyc();

        // Port 1 write followed immediately by port 0 read of the same address.
        single(1, 1'b1, 7'd9, 32'h00000011);
        single(0, 1'b0, 7'd9, 32'h00000011);
        cyc();
        chk("wr_rd_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
        chk("wr_rd_m0_rdata", bus.m0_rdata, 32'h00000011);
        repeat (2) cyc();

        // Reset the cycle after a read grant, with both requests held through the new sweep.
        single(0, 1'b0, 7'd5, 32'hDEADBEEF);
        set_port(0, 1'b1, 1'b0, 7'd5, 32'h0);
        set_port(1, 1'b1, 1'b0, 7'd6, 32'h0);
        do_reset();
        sweep(1'b1);
        e.port = 1'b0; e.data = 32'h0;
        sb.push_back(e);
        cyc();
        set_port(0, 1'b0, 1'b0, 7'd0, 32'h0);
        chk("after_clr_m0_read", 32'(bus.mem_memRead), 32'h1);
        chk("after_clr_m0_addr", 32'(bus.mem_addr), 32'd5);
        #1;
        chk("after_clr_m1_gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'h2);
        e.port = 1'b1; e.data = 32'h0;
        sb.push_back(e);
        cyc();
        set_port(1, 1'b0, 1'b0, 7'd0, 32'h0);
        chk("after_clr_m1_addr", 32'(bus.mem_addr), 32'd6);
        repeat (4) cyc();

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
